// File: rtl/mult_pkg.sv
// Shared definitions for the Booth multiplier family: FSM states and the
// radix-4 digit recoding used by every radix-4 partial-product generator.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    // Digit window is {q[2i+1], q[2i], q[2i-1]}
    localparam logic [2:0] BD_ZERO_LO = 3'b000;
    localparam logic [2:0] BD_P1_A    = 3'b001;
    localparam logic [2:0] BD_P1_B    = 3'b010;
    localparam logic [2:0] BD_P2      = 3'b011;
    localparam logic [2:0] BD_M2      = 3'b100;
    localparam logic [2:0] BD_M1_A    = 3'b101;
    localparam logic [2:0] BD_M1_B    = 3'b110;
    localparam logic [2:0] BD_ZERO_HI = 3'b111;

    typedef struct packed {
        logic neg;
        logic two;
        logic zero;
    } booth_sel_t;

    function automatic booth_sel_t booth_r4_digit(input logic [2:0] digit);
        booth_sel_t sel;
        sel.neg  = 1'b0;
        sel.two  = 1'b0;
        sel.zero = 1'b1;
        case (digit)
            BD_ZERO_LO, BD_ZERO_HI: begin
                sel.neg  = 1'b0;
                sel.two  = 1'b0;
                sel.zero = 1'b1;
            end
            BD_P1_A, BD_P1_B: begin
                sel.neg  = 1'b0;
                sel.two  = 1'b0;
                sel.zero = 1'b0;
            end
            BD_P2: begin
                sel.neg  = 1'b0;
                sel.two  = 1'b1;
                sel.zero = 1'b0;
            end
            BD_M2: begin
                sel.neg  = 1'b1;
                sel.two  = 1'b1;
                sel.zero = 1'b0;
            end
            BD_M1_A, BD_M1_B: begin
                sel.neg  = 1'b1;
                sel.two  = 1'b0;
                sel.zero = 1'b0;
            end
            default: begin
                sel.neg  = 1'b0;
                sel.two  = 1'b0;
                sel.zero = 1'b1;
            end
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_r4_pp_gen.sv
// Combinational radix-4 Booth partial-product generator: maps the extended
// multiplicand and one recoded digit to the W-bit term {0, +-M, +-2M}.
module booth_r4_pp_gen
    import mult_pkg::*;
#(
    parameter int W = 34
) (
    input  logic [W-1:0] i_mx,
    input  logic [2:0]   i_digit,
    output logic [W-1:0] o_term
);

    booth_sel_t     w_sel;
    logic [W-1:0]   w_mag;

    // Select magnitude, then negate in two's complement when the digit is negative
    always_comb begin
        w_sel = booth_r4_digit(i_digit);
        w_mag = {W{1'b0}};
        if (w_sel.zero) begin
            w_mag = {W{1'b0}};
        end else if (w_sel.two) begin
            w_mag = {i_mx[W-2:0], 1'b0};
        end else begin
            w_mag = i_mx;
        end
        if (w_sel.neg) begin
            o_term = ~w_mag + {{(W-1){1'b0}}, 1'b1};
        end else begin
            o_term = w_mag;
        end
    end

endmodule

// File: rtl/booth_radix4_seq_mult.sv
// Sequential radix-4 Booth multiplier: one digit per cycle, optional early exit
// once all remaining digits are zero, start/busy/done handshake.
module booth_radix4_seq_mult
    import mult_pkg::*;
#(
    parameter int N          = 32,
    parameter int EARLY_TERM = 1,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic               i_signed_mode,
    input  logic [N-1:0]       i_multiplicand,
    input  logic [N-1:0]       i_multiplier,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*N-1:0]     o_product,
    output logic [CNT_W-1:0]   o_cycle_count
);

    localparam int W      = N + 2;
    localparam int DIGITS = N / 2 + 1;
    localparam int CW     = $clog2(DIGITS + 1);
    localparam int SW     = CW + 1;

    mult_state_e        r_state;
    mult_state_e        w_state_next;

    logic [W-1:0]       r_mx;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_qx;
    logic               r_qm1;
    logic [CW-1:0]      r_cnt;
    logic [CNT_W-1:0]   r_iter;
    logic               r_busy;
    logic               r_done;
    logic [2*N-1:0]     r_product;
    logic [CNT_W-1:0]   r_cycle_count;

    logic [W-1:0]       w_mx_ext;
    logic [W-1:0]       w_qx_ext;
    logic [W-1:0]       w_term;
    logic [W-1:0]       w_a_sum;
    logic [2*W:0]       w_step;
    logic [SW-1:0]      w_shamt;
    logic [W-1:0]       w_mask;
    logic               w_rem_zero;
    logic               w_rem_ones;
    logic               w_early;
    logic [2*W-1:0]     w_early_shift;
    logic               w_last;
    logic               w_finish;
    logic               w_load;
    logic [CNT_W-1:0]   w_iter_inc;

    assign w_mx_ext = i_signed_mode ? {{2{i_multiplicand[N-1]}}, i_multiplicand}
                                    : {2'b00, i_multiplicand};
    assign w_qx_ext = i_signed_mode ? {{2{i_multiplier[N-1]}}, i_multiplier}
                                    : {2'b00, i_multiplier};

    booth_r4_pp_gen #(
        .W (W)
    ) u_pp_gen (
        .i_mx    (r_mx),
        .i_digit ({r_qx[1:0], r_qm1}),
        .o_term  (w_term)
    );

    assign w_a_sum = r_a + w_term;
    assign w_step  = $signed({w_a_sum, r_qx, r_qm1}) >>> 2'd2;

    // Remaining digits are all zero when the unconsumed multiplier bits plus qm1 are uniform
    assign w_shamt = {r_cnt, 1'b0};
    always_comb begin
        w_mask = {W{1'b0}};
        for (int i = 0; i < W; i++) begin
            w_mask[i] = (i < int'(w_shamt));
        end
    end

    assign w_rem_zero    = ((r_qx & w_mask) == {W{1'b0}}) && !r_qm1;
    assign w_rem_ones    = ((r_qx & w_mask) == w_mask) && r_qm1;
    assign w_early       = (EARLY_TERM != 0) && (w_rem_zero || w_rem_ones);
    assign w_early_shift = $signed({r_a, r_qx}) >>> w_shamt;
    assign w_last        = (r_cnt == CW'(1));
    assign w_finish      = (r_state == CALC) && (w_early || w_last);
    assign w_load        = i_start && (r_state != CALC);
    assign w_iter_inc    = (r_iter == {CNT_W{1'b1}}) ? r_iter : r_iter + CNT_W'(1);

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_next = CALC;
                end else begin
                    w_state_next = IDLE;
                end
            end
            CALC: begin
                if (w_early || w_last) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = CALC;
                end
            end
            DONE: begin
                if (i_start) begin
                    w_state_next = CALC;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand load, per-digit accumulate/shift and the early-exit barrel shift
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mx   <= {W{1'b0}};
            r_a    <= {W{1'b0}};
            r_qx   <= {W{1'b0}};
            r_qm1  <= 1'b0;
            r_cnt  <= {CW{1'b0}};
            r_iter <= {CNT_W{1'b0}};
        end else if (w_load) begin
            r_mx   <= w_mx_ext;
            r_a    <= {W{1'b0}};
            r_qx   <= w_qx_ext;
            r_qm1  <= 1'b0;
            r_cnt  <= CW'(DIGITS);
            r_iter <= {CNT_W{1'b0}};
        end else if (r_state == CALC) begin
            r_iter <= w_iter_inc;
            if (w_early) begin
                {r_a, r_qx} <= w_early_shift;
                r_qm1       <= 1'b0;
                r_cnt       <= {CW{1'b0}};
            end else begin
                r_a   <= w_step[2*W:W+1];
                r_qx  <= w_step[W:1];
                r_qm1 <= w_step[0];
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // Registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_product     <= {(2*N){1'b0}};
            r_cycle_count <= {CNT_W{1'b0}};
        end else begin
            r_busy <= (w_state_next == CALC);
            r_done <= (w_state_next == DONE);
            if (w_finish) begin
                r_product     <= w_early ? w_early_shift[2*N-1:0] : w_step[2*N:1];
                r_cycle_count <= w_iter_inc;
            end
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_product     = r_product;
    assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Self-checking bench: N=8 directed table on EARLY_TERM=1/0 pair, handshake
// corner sequences, and an N=32 regression against a reference product.
module tb_booth_radix4_seq_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        s8_start, s8_sm;
    logic [7:0]  s8_m, s8_q;
    logic        a_busy, a_done, b_busy, b_done;
    logic [15:0] a_prod, b_prod, a_cnt, b_cnt;

    logic        s32_start, s32_sm;
    logic [31:0] s32_m, s32_q;
    logic        c_busy, c_done, d_busy, d_done;
    logic [63:0] c_prod, d_prod;
    logic [15:0] c_cnt, d_cnt;

    booth_radix4_seq_mult #(.N(8), .EARLY_TERM(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .i_start(s8_start), .i_signed_mode(s8_sm),
        .i_multiplicand(s8_m), .i_multiplier(s8_q),
        .o_busy(a_busy), .o_done(a_done), .o_product(a_prod), .o_cycle_count(a_cnt));

    booth_radix4_seq_mult #(.N(8), .EARLY_TERM(0), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .i_start(s8_start), .i_signed_mode(s8_sm),
        .i_multiplicand(s8_m), .i_multiplier(s8_q),
        .o_busy(b_busy), .o_done(b_done), .o_product(b_prod), .o_cycle_count(b_cnt));

    booth_radix4_seq_mult #(.N(32), .EARLY_TERM(1), .CNT_W(16)) dut_c (
        .clk(clk), .reset(reset), .i_start(s32_start), .i_signed_mode(s32_sm),
        .i_multiplicand(s32_m), .i_multiplier(s32_q),
        .o_busy(c_busy), .o_done(c_done), .o_product(c_prod), .o_cycle_count(c_cnt));

    booth_radix4_seq_mult #(.N(32), .EARLY_TERM(0), .CNT_W(16)) dut_d (
        .clk(clk), .reset(reset), .i_start(s32_start), .i_signed_mode(s32_sm),
        .i_multiplicand(s32_m), .i_multiplier(s32_q),
        .o_busy(d_busy), .o_done(d_done), .o_product(d_prod), .o_cycle_count(d_cnt));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        sm;
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] prod;
        int          cnt_et;
    } vec_t;

    vec_t vecs[12];

    // One N=8 operation on both EARLY_TERM variants; optional start pulse at cycle poke_at
    task automatic run8(input logic sm, input logic [7:0] m, input logic [7:0] q, input int poke_at,
                        output logic [15:0] pa, output logic [15:0] pb,
                        output logic [15:0] ca, output logic [15:0] cb,
                        output int la, output int lb);
        la = -1; lb = -1; pa = 16'h0; pb = 16'h0; ca = 16'h0; cb = 16'h0;
        @(posedge clk); #1;
        s8_start = 1'b1; s8_sm = sm; s8_m = m; s8_q = q;
        @(posedge clk); #1;
        s8_start = 1'b0; s8_sm = ~sm; s8_m = ~m; s8_q = q ^ 8'h5A;
        for (int k = 1; k <= 20 && (la < 0 || lb < 0); k++) begin
            s8_start = (k == poke_at);
            if (a_done && la < 0) begin la = k; pa = a_prod; ca = a_cnt; end
            if (b_done && lb < 0) begin lb = k; pb = b_prod; cb = b_cnt; end
            @(posedge clk); #1;
        end
        s8_start = 1'b0;
    endtask

    task automatic run32(input logic sm, input logic [31:0] m, input logic [31:0] q,
                         output logic [63:0] pc, output logic [63:0] pd,
                         output logic [15:0] cc, output logic [15:0] cd,
                         output int lc, output int ld);
        lc = -1; ld = -1; pc = 64'h0; pd = 64'h0; cc = 16'h0; cd = 16'h0;
        @(posedge clk); #1;
        s32_start = 1'b1; s32_sm = sm; s32_m = m; s32_q = q;
        @(posedge clk); #1;
        s32_start = 1'b0; s32_m = $urandom; s32_q = $urandom; s32_sm = ~sm;
        for (int k = 1; k <= 30 && (lc < 0 || ld < 0); k++) begin
            if (c_done && lc < 0) begin lc = k; pc = c_prod; cc = c_cnt; end
            if (d_done && ld < 0) begin ld = k; pd = d_prod; cd = d_cnt; end
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] pick32();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'h7FFF_FFFF;
            4:       v = 32'($urandom_range(0, 15));
            5:       v = $urandom & 32'h0000_FFFF;
            6:       v = $urandom | 32'hFFFF_0000;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // CALC cycles with early exit: first step whose remaining window {Qx[33:2s-2], qm1} is uniform
    function automatic int et_cycles(input logic [33:0] qx);
        logic [34:0] v;
        bit uni;
        v = {qx, 1'b0};
        for (int s = 1; s <= 17; s++) begin
            uni = 1'b1;
            for (int i = 2 * s - 2; i <= 34; i++) begin
                if (v[i] != v[2 * s - 2]) uni = 1'b0;
            end
            if (uni) return s;
        end
        return 17;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pa, pb, ca, cb;
        int          la, lb;
        logic [63:0] pc, pd, exp64;
        logic [15:0] cc, cd;
        int          lc, ld, ec;
        logic        sm;
        logic [31:0] m, q;
        int          d1, d2;
        int          phase;

        vecs[0]  = '{1'b1, 8'hF9, 8'h03, 16'hFFEB, 3};
        vecs[1]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 5};
        vecs[2]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 2};
        vecs[3]  = '{1'b1, 8'h80, 8'h80, 16'h4000, 5};
        vecs[4]  = '{1'b1, 8'h80, 8'h7F, 16'hC080, 5};
        vecs[5]  = '{1'b1, 8'h05, 8'h00, 16'h0000, 1};
        vecs[6]  = '{1'b0, 8'hFF, 8'h00, 16'h0000, 1};
        vecs[7]  = '{1'b0, 8'h80, 8'h80, 16'h4000, 5};
        vecs[8]  = '{1'b1, 8'h7F, 8'h7F, 16'h3F01, 5};
        vecs[9]  = '{1'b1, 8'h03, 8'hFF, 16'hFFFD, 2};
        vecs[10] = '{1'b0, 8'h0C, 8'h01, 16'h000C, 2};
        vecs[11] = '{1'b1, 8'hFE, 8'h04, 16'hFFF8, 3};

        reset = 1'b1;
        s8_start = 1'b0; s8_sm = 1'b0; s8_m = 8'h0; s8_q = 8'h0;
        s32_start = 1'b0; s32_sm = 1'b0; s32_m = 32'h0; s32_q = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_busy_a", 64'(a_busy), 64'd0);
        check("rst_done_a", 64'(a_done), 64'd0);
        check("rst_prod_a", 64'(a_prod), 64'd0);
        check("rst_cnt_a",  64'(a_cnt),  64'd0);
        check("rst_busy_c", 64'(c_busy), 64'd0);
        check("rst_prod_c", c_prod,      64'd0);

        for (int i = 0; i < 12; i++) begin
            run8(vecs[i].sm, vecs[i].m, vecs[i].q, 0, pa, pb, ca, cb, la, lb);
            check($sformatf("vec%0d_prod_et1", i), 64'(pa), 64'(vecs[i].prod));
            check($sformatf("vec%0d_prod_et0", i), 64'(pb), 64'(vecs[i].prod));
            check($sformatf("vec%0d_cnt_et1", i),  64'(ca), 64'(vecs[i].cnt_et));
            check($sformatf("vec%0d_cnt_et0", i),  64'(cb), 64'd5);
            check($sformatf("vec%0d_lat_et1", i),  64'(la), 64'(vecs[i].cnt_et + 1));
            check($sformatf("vec%0d_lat_et0", i),  64'(lb), 64'd6);
        end

        // start pulsed while busy must not disturb the running op
        run8(1'b1, 8'h7F, 8'h7F, 2, pa, pb, ca, cb, la, lb);
        check("poke_prod_et1", 64'(pa), 64'h3F01);
        check("poke_prod_et0", 64'(pb), 64'h3F01);
        check("poke_lat_et1",  64'(la), 64'd6);
        repeat (4) @(posedge clk);
        #1;
        check("poke_idle_a", 64'(a_busy), 64'd0);
        check("poke_idle_b", 64'(b_busy), 64'd0);
        check("poke_hold_a", 64'(a_prod), 64'h3F01);

        // reset in the middle of CALC
        @(posedge clk); #1;
        s8_start = 1'b1; s8_sm = 1'b1; s8_m = 8'hF9; s8_q = 8'h03;
        @(posedge clk); #1;
        s8_start = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy_before", 64'(a_busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_busy_a", 64'(a_busy), 64'd0);
        check("midrst_done_a", 64'(a_done), 64'd0);
        check("midrst_prod_a", 64'(a_prod), 64'd0);
        check("midrst_busy_b", 64'(b_busy), 64'd0);
        check("midrst_prod_b", 64'(b_prod), 64'd0);
        run8(1'b1, 8'hFE, 8'h04, 0, pa, pb, ca, cb, la, lb);
        check("after_rst_prod_a", 64'(pa), 64'hFFF8);
        check("after_rst_prod_b", 64'(pb), 64'hFFF8);
        check("after_rst_cnt_a",  64'(ca), 64'd3);

        // back-to-back: start held high through DONE of the early-terminating unit
        @(posedge clk); #1;
        s8_start = 1'b1; s8_sm = 1'b1; s8_m = 8'hF9; s8_q = 8'h03;
        @(posedge clk); #1;
        s8_sm = 1'b0; s8_m = 8'h0C; s8_q = 8'h01;
        d1 = -1; d2 = -1; lb = -1; pb = 16'h0; phase = 0;
        for (int k = 1; k <= 30 && (d2 < 0 || lb < 0); k++) begin
            if (phase == 0 && a_done) begin
                d1 = k;
                check("b2b_prod1", 64'(a_prod), 64'hFFEB);
                check("b2b_cnt1",  64'(a_cnt),  64'd3);
                phase = 1;
            end else if (phase == 1) begin
                check("b2b_busy_resume", 64'(a_busy), 64'd1);
                check("b2b_done_low",    64'(a_done), 64'd0);
                s8_start = 1'b0;
                phase = 2;
            end else if (phase == 2 && a_done && d2 < 0) begin
                d2 = k;
                check("b2b_prod2", 64'(a_prod), 64'h000C);
                check("b2b_cnt2",  64'(a_cnt),  64'd2);
            end
            if (b_done && lb < 0) begin lb = k; pb = b_prod; end
            @(posedge clk); #1;
        end
        s8_start = 1'b0;
        check("b2b_done1_cycle", 64'(d1), 64'd4);
        check("b2b_done2_cycle", 64'(d2), 64'd7);
        check("b2b_prod_et0",    64'(pb), 64'hFFEB);
        check("b2b_lat_et0",     64'(lb), 64'd6);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_idle_a", 64'(a_busy), 64'd0);

        // N=32 regression on both EARLY_TERM variants
        for (int i = 0; i < 1500; i++) begin
            sm = 1'($urandom_range(0, 1));
            m  = pick32();
            q  = pick32();
            run32(sm, m, q, pc, pd, cc, cd, lc, ld);
            if (sm) begin
                exp64 = 64'($signed({{32{m[31]}}, m}) * $signed({{32{q[31]}}, q}));
                ec    = et_cycles({{2{q[31]}}, q});
            end else begin
                exp64 = {32'h0, m} * {32'h0, q};
                ec    = et_cycles({2'b00, q});
            end
            check("rnd_prod_et1", pc, exp64);
            check("rnd_prod_et0", pd, exp64);
            check("rnd_cnt_et1",  64'(cc), 64'(ec));
            check("rnd_cnt_et0",  64'(cd), 64'd17);
            check("rnd_lat_et1",  64'(lc), 64'(ec + 1));
            check("rnd_lat_et0",  64'(ld), 64'd18);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
